// File: rtl/md_sequencer_pkg.sv
// Shared op codes, Execute HI/LO select codes and decode helpers for the
// multiply/divide sequencer.
package md_sequencer_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  // Execute-stage OUTop select codes that route HI/LO onto the result bus.
  localparam logic [2:0] OUT_HI   = 3'b011;
  localparam logic [2:0] OUT_LO   = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdState_t;

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle busy window.
  function automatic logic isLongOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || isDivOp(op);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
// Produces {hi,lo} and flags a zero divisor on div/divu.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [63:0] result,
  output logic        divByZero
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [31:0] divB;
  logic [31:0] quotU;
  logic [31:0] remU;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] quotM;
  logic [31:0] remM;
  logic [31:0] quotS;
  logic [31:0] remS;

  // Sign-extend to 64 bits so the low 64 bits of the product are the signed result.
  assign prodS = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
  assign prodU = {32'd0, srcA} * {32'd0, srcB};

  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign divB  = (srcB == 32'd0) ? 32'd1 : srcB;
  assign quotU = srcA / divB;
  assign remU  = srcA % divB;

  // Signed divide on magnitudes: quotient truncates toward zero, remainder follows
  // the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0 from the wrap.
  assign magA  = srcA[31] ? (32'd0 - srcA) : srcA;
  assign magB  = (srcB == 32'd0) ? 32'd1 : (srcB[31] ? (32'd0 - srcB) : srcB);
  assign quotM = magA / magB;
  assign remM  = magA % magB;
  assign quotS = (srcA[31] ^ srcB[31]) ? (32'd0 - quotM) : quotM;
  assign remS  = srcA[31] ? (32'd0 - remM) : remM;

  assign divByZero = isDivOp(op) && (srcB == 32'd0);

  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prodS;
      MD_MULTU: result = prodU;
      MD_DIV:   result = {remS, quotS};
      MD_DIVU:  result = {remU, quotU};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the Execute stage: fixed-latency busy window,
// HI/LO commit, and the Decode-stage HI/LO hazard stall.
//
//   state | meaning
//   IDLE  | unit free; accepts mult/div (-> RUN) and mthi/mtlo (direct write)
//   RUN   | op in flight; counter counts down, commit when it reaches 1
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mult_div_op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        md_instr_D,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        stall_md
);

  mdState_t         state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       opQ;
  logic [31:0]      srcAQ;
  logic [31:0]      srcBQ;
  logic [63:0]      arithResult;
  logic             divByZero;

  md_arith uArith (
    .op        (opQ),
    .srcA      (srcAQ),
    .srcB      (srcBQ),
    .result    (arithResult),
    .divByZero (divByZero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      opQ   <= 3'd0;
      srcAQ <= 32'd0;
      srcBQ <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (isLongOp(mult_div_op)) begin
              opQ   <= mult_div_op;
              srcAQ <= D1;
              srcBQ <= D2;
              cnt   <= isDivOp(mult_div_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state <= RUN;
            end else if (mult_div_op == MD_MTHI) begin
              HI <= D1;
            end else if (mult_div_op == MD_MTLO) begin
              LO <= D1;
            end
          end
        end
        RUN: begin
          // start is ignored here; stall_md keeps legal streams from issuing.
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= IDLE;
            if (!divByZero) begin
              HI <= arithResult[63:32];
              LO <= arithResult[31:0];
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy     = (state == RUN);
  assign stall_md = md_instr_D & (start | Busy);

endmodule
